majority_voter_seq: RTL

- Registered, parametrised N-way bitwise majority voter for redundant W-bit channels.
- Each valid sample is voted over all channels not currently faulted.
- Tracks consecutive disagreements per channel and isolates a channel after FAIL_LIMIT consecutive mismatches.
- Sits between replicated datapaths and the single consumer downstream; the consumer sees one voted word per sample plus health flags.

---
 rtl/majority_voter_seq_if.sv | 25 ++
 rtl/majority_voter_seq.sv | 105 ++++++++++
 2 files changed

// File: rtl/majority_voter_seq_if.sv
// Voter bus: replicated samples in, voted word and health flags out.
// Ports: in_valid/in_data/clear_fault (to voter); out_* / mismatch / fault / no_quorum (from voter).
interface majority_voter_seq_if #(
  parameter int W = 8,
  parameter int N = 3
);
  logic         in_valid;
  logic [N*W-1:0] in_data;
  logic         clear_fault;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [N-1:0] mismatch;
  logic [N-1:0] fault;
  logic         no_quorum;

  modport master (
    output in_valid, in_data, clear_fault,
    input  out_valid, out_data, mismatch, fault, no_quorum
  );

  modport slave (
    input  in_valid, in_data, clear_fault,
    output out_valid, out_data, mismatch, fault, no_quorum
  );
endinterface

// File: rtl/majority_voter_seq.sv
// Registered N-way bitwise majority voter with per-channel fault isolation.
// Ports: clk, rst (sync, active-high), bus (slave side of majority_voter_seq_if).
module majority_voter_seq #(
  parameter int W          = 8,
  parameter int N          = 3,
  parameter int FAIL_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  majority_voter_seq_if.slave bus
);

  localparam int CW  = $clog2(FAIL_LIMIT + 1);
  localparam int CNW = $clog2(N + 1);
  localparam logic [CNW-1:0] C1  = CNW'(1);
  localparam logic [CW-1:0]  LIM = CW'(FAIL_LIMIT);
  localparam logic [CW-1:0]  K1  = CW'(1);

  logic [W-1:0]   word [N];
  logic [N-1:0]   act;
  logic [CNW-1:0] m;
  logic [CNW-1:0] ones;
  logic [W-1:0]   first_word;
  logic [W-1:0]   vote;
  logic [N-1:0]   mis;

  logic [CW-1:0]  cnt [N];
  logic [N-1:0]   fault_q;

  assign bus.fault = fault_q;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      word[k] = bus.in_data[k*W +: W];
    end
  end

  // With no active channel every bit ties and first_word is zero,
  // so the M=0 case falls out as out_data=0 and mismatch=0.
  always_comb begin
    act        = ~fault_q;
    m          = '0;
    ones       = '0;
    first_word = '0;
    vote       = '0;
    mis        = '0;
    for (int k = 0; k < N; k++) begin
      if (act[k]) m = m + C1;
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (act[k]) first_word = word[k];
    end
    for (int b = 0; b < W; b++) begin
      ones = '0;
      for (int k = 0; k < N; k++) begin
        if (act[k] && word[k][b]) ones = ones + C1;
      end
      if ({ones, 1'b0} > {1'b0, m})
        vote[b] = 1'b1;
      else if ({ones, 1'b0} < {1'b0, m})
        vote[b] = 1'b0;
      else
        vote[b] = first_word[b];
    end
    for (int k = 0; k < N; k++) begin
      mis[k] = act[k] && (word[k] != vote);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.mismatch  <= '0;
      bus.no_quorum <= 1'b0;
    end else if (bus.in_valid) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= vote;
      bus.mismatch  <= mis;
      bus.no_quorum <= (m < CNW'(2));
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

  // Clear overrides any increment or fault set on the same edge.
  always_ff @(posedge clk) begin
    if (rst || bus.clear_fault) begin
      fault_q <= '0;
      for (int k = 0; k < N; k++) cnt[k] <= '0;
    end else if (bus.in_valid) begin
      for (int k = 0; k < N; k++) begin
        if (act[k]) begin
          if (!mis[k]) begin
            cnt[k] <= '0;
          end else if (cnt[k] != LIM) begin
            cnt[k] <= cnt[k] + K1;
            if (cnt[k] + K1 == LIM) fault_q[k] <= 1'b1;
          end
        end
      end
    end
  end

endmodule
